fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core configuration for the instruction fetch stage: address map,
// ROM latency and the fetch FSM state type.
package fetch_unit_pkg;

    localparam int              XLEN          = 32;
    localparam int              IF_LATENCY    = 2;
    localparam int              IF_INC        = 4;
    localparam logic [XLEN-1:0] IF_BOOT_ADDR  = 32'h1000_0000;
    localparam logic [XLEN-1:0] IF_BASE_ADDR  = 32'h1000_0000;
    localparam logic [XLEN-1:0] IF_MAX_ADDR   = 32'h1000_3FFF;
    localparam int              IF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush, occupancy count and
// same-cycle push/pop.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // The upstream issue throttle must make this impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && full && !do_pop));

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: PC generation, fixed-latency ROM tracking and output
// buffering. FETCH_RANGE_CHECK_EN adds the FAULT state and fault outputs.
module fetch_unit #(
    parameter int              XLEN         = fetch_unit_pkg::XLEN,
    parameter int              IF_LATENCY   = fetch_unit_pkg::IF_LATENCY,
    parameter int              IF_INC       = fetch_unit_pkg::IF_INC,
    parameter logic [XLEN-1:0] IF_BOOT_ADDR = fetch_unit_pkg::IF_BOOT_ADDR,
    parameter logic [XLEN-1:0] IF_BASE_ADDR = fetch_unit_pkg::IF_BASE_ADDR,
    parameter logic [XLEN-1:0] IF_MAX_ADDR  = fetch_unit_pkg::IF_MAX_ADDR,
    parameter int              FIFO_DEPTH   = fetch_unit_pkg::IF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            rom_en,
    output logic [XLEN-1:0] rom_addr,
    input  logic [31:0]     rom_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_addr
);
    import fetch_unit_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d, pc_inc;
    logic [IF_LATENCY-1:0] trk_vld_q, trk_vld_d;
    logic [XLEN-1:0]     trk_pc_q [IF_LATENCY];
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       inflight_count;
    logic                fifo_empty;
    logic [XLEN+31:0]    fifo_head;
    logic                issue;
    logic                pop;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < IF_LATENCY; i++) begin
            inflight_count = inflight_count + CW'(trk_vld_q[i]);
        end
    end

    // Conservative throttle: a pop in this same cycle is not credited.
    assign issue = (state_q == RUN) && !redirect_valid &&
                   (({1'b0, fifo_count} + {1'b0, inflight_count}) < (CW+1)'(FIFO_DEPTH));

    assign rom_en    = issue;
    assign rom_addr  = issue ? pc_q : '0;
    assign valid_out = !fifo_empty && !redirect_valid;
    assign pop       = valid_out && ready_in;
    assign pc_out    = valid_out ? fifo_head[XLEN+31:32] : '0;
    assign instr_out = valid_out ? fifo_head[31:0] : '0;

`ifdef FETCH_RANGE_CHECK_EN
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;

    function automatic logic addr_ok(input logic [XLEN-1:0] a);
        return (a >= IF_BASE_ADDR) && (a <= IF_MAX_ADDR - XLEN'(3)) && (a[1:0] == 2'b00);
    endfunction

    assign fetch_fault = fault_q;
    assign fault_addr  = fault_addr_q;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_addr[1:0];
    assign fetch_fault = 1'b0;
    assign fault_addr  = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_inc  = pc_q + XLEN'(IF_INC);
`ifdef FETCH_RANGE_CHECK_EN
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
`endif
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (issue) begin
`ifdef FETCH_RANGE_CHECK_EN
                    pc_d = pc_inc;
                    if (!addr_ok(pc_inc)) begin
                        state_d      = FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = pc_inc;
                    end
`else
                    pc_d = ((pc_inc > IF_MAX_ADDR) || (pc_inc < IF_BASE_ADDR)) ? IF_BASE_ADDR : pc_inc;
`endif
                end
            end
            FAULT: ;
            default: state_d = BOOT;
        endcase
        if (redirect_valid) begin
            pc_d    = {redirect_addr[XLEN-1:2], 2'b00};
            state_d = RUN;
`ifdef FETCH_RANGE_CHECK_EN
            if (addr_ok(redirect_addr)) begin
                fault_d      = 1'b0;
                fault_addr_d = '0;
            end else begin
                state_d      = FAULT;
                fault_d      = 1'b1;
                fault_addr_d = redirect_addr;
            end
`endif
        end
    end

    // A redirect kills every in-flight slot so late ROM data is dropped.
    always_comb begin
        trk_vld_d = '0;
        if (!redirect_valid) begin
            trk_vld_d[0] = issue;
            for (int i = 1; i < IF_LATENCY; i++) begin
                trk_vld_d[i] = trk_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= IF_BOOT_ADDR;
            trk_vld_q <= '0;
`ifdef FETCH_RANGE_CHECK_EN
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trk_vld_q <= trk_vld_d;
`ifdef FETCH_RANGE_CHECK_EN
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        trk_pc_q[0] <= pc_q;
        for (int i = 1; i < IF_LATENCY; i++) begin
            trk_pc_q[i] <= trk_pc_q[i-1];
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (trk_vld_q[IF_LATENCY-1]),
        .push_data_i ({trk_pc_q[IF_LATENCY-1], rom_data}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 2-cycle ROM model returning addr^A5A5_0000
// and a queue of expected pcs checked on every handshake.
module tb_fetch_unit;

    localparam logic [31:0] MASK   = 32'hA5A5_0000;
    localparam logic [31:0] BOOT_A = 32'h1000_0000;
    localparam logic [31:0] BASE_A = 32'h1000_0000;
    localparam logic [31:0] MAX_A  = 32'h1000_3FFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= rom_addr;
        rd2 <= rd1;
    end
    assign rom_data = rd2 ^ MASK;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .fetch_fault    (fetch_fault),
        .fault_addr     (fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
            if (a > MAX_A) a = BASE_A;
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then score any handshake.
    task automatic cyc(input logic rst, input logic rv, input logic [31:0] ra, input logic rdy);
        logic [31:0] e;
        @(negedge clk);
        rst_n          = rst;
        redirect_valid = rv;
        redirect_addr  = ra;
        ready_in       = rdy;
        #1;
        if (rst && valid_out && ready_in) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("hs_pc", pc_out, e);
            chk("hs_instr", instr_out, e ^ MASK);
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; ready_in = 1'b0;

        // Reset values
        repeat (3) cyc(0, 0, 0, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_fault_addr", fault_addr, 0);

        // Boot: BOOT cycle, issue in cycle 2, first output 3 cycles later
        load_q(BOOT_A);
        cyc(1, 0, 0, 1); chk("boot_no_issue", rom_en, 0);
        cyc(1, 0, 0, 1); chk("first_en", rom_en, 1); chk("first_addr", rom_addr, BOOT_A);
        cyc(1, 0, 0, 1); chk("first_lat_a", valid_out, 0);
        cyc(1, 0, 0, 1); chk("first_lat_b", valid_out, 0);
        cyc(1, 0, 0, 1); chk("first_valid", valid_out, 1);
        repeat (8) begin cyc(1, 0, 0, 1); chk("stream_valid", valid_out, 1); end

        // Backpressure: fills to 4 and stops issuing; resumes without gaps
        repeat (10) cyc(1, 0, 0, 0);
        chk("stall_no_issue", rom_en, 0);
        chk("stall_fifo_full", 32'(dut.fifo_count), 4);
        chk("stall_valid", valid_out, 1);
        repeat (12) begin cyc(1, 0, 0, 1); chk("resume_valid", valid_out, 1); end

        // Redirect with entries buffered and in flight, ready high same cycle
        cyc(1, 0, 0, 0);
        cyc(1, 1, 32'h1000_0100, 1);
        chk("redir_valid_low", valid_out, 0);
        chk("redir_no_issue", rom_en, 0);
        load_q(32'h1000_0100);
        cyc(1, 0, 0, 1); chk("reissue_en", rom_en, 1); chk("reissue_addr", rom_addr, 32'h1000_0100);
        cyc(1, 0, 0, 1); chk("redir_lat_a", valid_out, 0);
        cyc(1, 0, 0, 1); chk("redir_lat_b", valid_out, 0);
        cyc(1, 0, 0, 1); chk("redir_first_valid", valid_out, 1);
        repeat (6) cyc(1, 0, 0, 1);

        // End of fetchable range
        cyc(1, 1, 32'h1000_3FFC, 1);
        load_q(32'h1000_3FFC);
        cyc(1, 0, 0, 1); chk("top_addr", rom_addr, 32'h1000_3FFC);
`ifdef FETCH_RANGE_CHECK_EN
        cyc(1, 0, 0, 1);
        chk("ovr_fault", fetch_fault, 1);
        chk("ovr_fault_addr", fault_addr, 32'h1000_4000);
        chk("ovr_no_issue", rom_en, 0);
        cyc(1, 0, 0, 1); chk("ovr_lat", valid_out, 0);
        cyc(1, 0, 0, 1); chk("ovr_drain", valid_out, 1);
        cyc(1, 0, 0, 1); chk("ovr_empty", valid_out, 0);
        cyc(1, 1, 32'h1000_0002, 1);
        exp_q.delete();
        cyc(1, 0, 0, 1);
        chk("mis_fault", fetch_fault, 1);
        chk("mis_fault_addr", fault_addr, 32'h1000_0002);
        chk("mis_no_issue", rom_en, 0);
`else
        cyc(1, 0, 0, 1); chk("wrap_addr", rom_addr, BASE_A);
        cyc(1, 0, 0, 1);
        repeat (4) begin cyc(1, 0, 0, 1); chk("wrap_valid", valid_out, 1); end
        cyc(1, 1, 32'h1000_0002, 1);
        load_q(32'h1000_0000);
        cyc(1, 0, 0, 1); chk("mask_addr", rom_addr, 32'h1000_0000);
        repeat (6) cyc(1, 0, 0, 1);
`endif

        // Good redirect clears any fault
        cyc(1, 1, 32'h1000_0200, 1);
        load_q(32'h1000_0200);
        cyc(1, 0, 0, 1);
        chk("clr_fault", fetch_fault, 0);
        chk("clr_fault_addr", fault_addr, 0);
        chk("clr_addr", rom_addr, 32'h1000_0200);
        repeat (8) cyc(1, 0, 0, 1);

        // One-cycle reset with fetches in flight
        cyc(0, 0, 0, 1);
        load_q(BOOT_A);
        cyc(1, 0, 0, 1);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_en", rom_en, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_pc", pc_out, 0);
        chk("mid_rst_instr", instr_out, 0);
        cyc(1, 0, 0, 1); chk("restart_addr", rom_addr, BOOT_A);
        cyc(1, 0, 0, 1); chk("late_data_a", valid_out, 0);
        cyc(1, 0, 0, 1); chk("late_data_b", valid_out, 0);
        cyc(1, 0, 0, 1); chk("restart_valid", valid_out, 1);
        repeat (4) cyc(1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
